aes_engine_ctrl: RTL and testbench
==================================

// Module: aes_engine_ctrl
// PURPOSE
//  Sequencing controller for the AES HWPE datapath. Gathers NB_WORDS 32-bit input beats into the
//  128-bit block register (word select + load strobe), then fires the AES core and waits for it.
//  It then streams the result back out one word per handshake, and repeats for a programmed block count.
//  Sits between the HWPE register file/streamer (start, count, stream handshakes) and the engine datapath.
// PARAMETERS
//  NB_WORDS       4     32-bit words per AES block (power of two, >=2)
//  BLK_CNT_W      16    width of the programmed block count
//  TIMEOUT_CYCLES 1024  core watchdog limit, used only with AES_CTRL_TIMEOUT_EN
// PORTS
//  clk_i          in   1                    clock
//  rst_ni         in   1                    synchronous reset, active-low
//  clear_i        in   1                    soft clear, returns to IDLE
//  start_i        in   1                    job start pulse (sampled in IDLE only)
//  nb_blocks_i    in   BLK_CNT_W            blocks in job, latched on start
//  in_valid_i     in   1                    input stream valid
//  in_ready_o     out  1                    input stream ready
//  out_valid_o    out  1                    output stream valid (to d_o.valid)
//  out_ready_i    in   1                    output stream ready
//  word_idx_o     out  $clog2(NB_WORDS)     word select for load/unload mux
//  load_en_o      out  1                    write input word word_idx_o into block register
//  core_start_o   out  1                    one-cycle AES core start
//  core_done_i    in   1                    AES core finished (pulse or level)
//  busy_o         out  1                    state != IDLE
//  done_o         out  1                    one-cycle job-complete pulse
//  blk_cnt_o      out  BLK_CNT_W            blocks fully unloaded in current job
//  err_o          out  1                    watchdog error (AES_CTRL_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
//  - Clock clk_i; reset rst_ni is synchronous, active-low. Reset: state IDLE, all counters 0,
//    all outputs 0. clear_i acts identically to reset; reset takes priority over clear_i.
//  - States: IDLE, LOAD, START, WAIT_CORE, UNLOAD, DONE.
//  - IDLE: on start_i latch nb_blocks_i. If nonzero -> LOAD; if zero -> DONE. Otherwise stay.
//  - LOAD: in_ready_o=1. A beat is accepted when in_valid_i&in_ready_o; load_en_o=in_valid_i,
//    combinational from the handshake, same cycle. word_idx_o=word_cnt; word_cnt++ per beat.
//    Beat NB_WORDS-1 wraps word_cnt to 0 and moves to START.
//  - START: core_start_o=1 for exactly one cycle -> WAIT_CORE. in_ready_o=0 from here until the next LOAD.
//  - WAIT_CORE: on core_done_i -> UNLOAD. A core_done_i outside WAIT_CORE is ignored.
//  - UNLOAD: out_valid_o=1, word_idx_o=word_cnt. Advance on out_ready_i. Valid is never dropped
//    without a handshake, and word_idx_o is stable while stalled.
//  - After the last word of a block, blk_cnt_o++. Go to DONE if blk_cnt_o+1==latched count, else to LOAD.
//  - DONE: done_o=1 for one cycle -> IDLE. blk_cnt_o holds until the next start_i, which zeroes it.
//  - start_i outside IDLE is ignored. nb_blocks_i changes after start have no effect.
//  - Latency per block (no stalls): NB_WORDS load + 1 start + core + NB_WORDS unload cycles.
//  - in_valid_i and out_ready_i are never both consumed in one cycle: no overlap of load and unload.
// CONFIGURATION
//  - AES_CTRL_TIMEOUT_EN defined: a cycle counter runs in WAIT_CORE and resets on entry.
//    If it reaches TIMEOUT_CYCLES without core_done_i, the FSM goes to DONE and err_o is set.
//    err_o is sticky until the next start_i, clear_i or reset. done_o still pulses.
//  - AES_CTRL_TIMEOUT_EN undefined: no counter, WAIT_CORE waits indefinitely, err_o tied 0.
// TESTING
//  1. Reset mid-LOAD, after 2 beats -> next cycle IDLE, word_idx_o=0, busy_o=0, in_ready_o=0.
//  2. start, nb_blocks=1, words 0x0..0x3, done after 10 cycles -> core_start_o 1 pulse, out idx 0..3, done_o once, blk_cnt_o=1.
//  3. nb_blocks=3, out_ready_i toggling 50% -> 12 output beats, word_idx_o stable on stalls, blk_cnt_o=3.
//  4. start with nb_blocks=0 -> done_o the cycle after DONE entry, no in_ready_o/core_start_o, blk_cnt_o=0.
//  5. start_i pulsed during WAIT_CORE, spurious core_done_i in LOAD -> both ignored; job completes normally.
//  6. TIMEOUT_EN, TIMEOUT_CYCLES=16, core_done_i never -> err_o=1 and done_o after 16 WAIT_CORE cycles.

Source files
------------

// File: rtl/aes_engine_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// aes_engine_ctrl
// Sequencing controller for the AES HWPE datapath. It gathers NB_WORDS 32-bit
// input beats into the 128-bit block register, fires the AES core, waits for
// it, streams the result back one word per handshake, and repeats for the
// programmed number of blocks.
//
// Optional feature macro: AES_CTRL_TIMEOUT_EN
//   defined   : a watchdog counts WAIT_CORE cycles. After TIMEOUT_CYCLES cycles
//               without core_done_i the job ends in DONE and err_o is raised.
//               err_o stays set until the next accepted start_i, clear_i or reset.
//   undefined : WAIT_CORE waits indefinitely and err_o is tied low.
//
// Ports
//   clk_i         clock
//   rst_ni        synchronous reset, active-low (has priority over clear_i)
//   clear_i       soft clear, same effect as reset
//   start_i       job start pulse, only sampled in IDLE
//   nb_blocks_i   number of blocks in the job, latched on start
//   in_valid_i    input stream valid
//   in_ready_o    input stream ready (high in LOAD)
//   out_valid_o   output stream valid (high in UNLOAD)
//   out_ready_i   output stream ready
//   word_idx_o    word select for the block register load/unload mux
//   load_en_o     write the current input word into the block register
//   core_start_o  one-cycle AES core start
//   core_done_i   AES core finished (pulse or level)
//   busy_o        controller is not idle
//   done_o        one-cycle job-complete pulse
//   blk_cnt_o     blocks fully unloaded in the current job
//   err_o         watchdog error
// -----------------------------------------------------------------------------
module aes_engine_ctrl #(
  parameter int NB_WORDS       = 4,
  parameter int BLK_CNT_W      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        start_i,
  input  logic [BLK_CNT_W-1:0]        nb_blocks_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [$clog2(NB_WORDS)-1:0] word_idx_o,
  output logic                        load_en_o,
  output logic                        core_start_o,
  input  logic                        core_done_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [BLK_CNT_W-1:0]        blk_cnt_o,
  output logic                        err_o
);

  localparam int IDX_W = $clog2(NB_WORDS);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(NB_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_CORE,
    UNLOAD,
    DONE
  } state_t;

  state_t               state_reg;
  logic [IDX_W-1:0]     word_cnt_reg;
  logic [BLK_CNT_W-1:0] blk_cnt_reg;
  logic [BLK_CNT_W-1:0] nb_blocks_reg;
  logic                 in_ready_reg;
  logic                 out_valid_reg;
  logic                 core_start_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 timeout_hit;

`ifdef AES_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             err_reg;

  // Fires in the TIMEOUT_CYCLES-th WAIT_CORE cycle if the core is still silent;
  // a done arriving in that same cycle wins.
  assign timeout_hit = (state_reg == WAIT_CORE) && !core_done_i &&
                       (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      tmo_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      // START always precedes WAIT_CORE, so clearing there restarts the count on entry
      if (state_reg == START) begin
        tmo_cnt_reg <= '0;
      end else if (state_reg == WAIT_CORE) begin
        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
      end

      if (state_reg == IDLE && start_i) begin
        err_reg <= 1'b0;
      end else if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err_o = err_reg;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign err_o          = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // Stream/strobe outputs are registered alongside the state so they change
  // exactly on state transitions.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_reg      <= IDLE;
      word_cnt_reg   <= '0;
      blk_cnt_reg    <= '0;
      nb_blocks_reg  <= '0;
      in_ready_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      core_start_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      core_start_reg <= 1'b0;
      done_reg       <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start_i) begin
            nb_blocks_reg <= nb_blocks_i;
            blk_cnt_reg   <= '0;
            busy_reg      <= 1'b1;
            if (nb_blocks_i != '0) begin
              state_reg    <= LOAD;
              in_ready_reg <= 1'b1;
            end else begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (in_valid_i) begin
            if (word_cnt_reg == LAST_WORD) begin
              word_cnt_reg   <= '0;
              state_reg      <= START;
              in_ready_reg   <= 1'b0;
              core_start_reg <= 1'b1;
            end else begin
              word_cnt_reg <= word_cnt_reg + IDX_W'(1);
            end
          end
        end

        START: begin
          state_reg <= WAIT_CORE;
        end

        WAIT_CORE: begin
          if (core_done_i) begin
            state_reg     <= UNLOAD;
            out_valid_reg <= 1'b1;
          end else if (timeout_hit) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end

        UNLOAD: begin
          // Valid and word index only move on a completed handshake.
          if (out_ready_i) begin
            if (word_cnt_reg == LAST_WORD) begin
              word_cnt_reg  <= '0;
              blk_cnt_reg   <= blk_cnt_reg + BLK_CNT_W'(1);
              out_valid_reg <= 1'b0;
              if (blk_cnt_reg + BLK_CNT_W'(1) == nb_blocks_reg) begin
                state_reg <= DONE;
                done_reg  <= 1'b1;
              end else begin
                state_reg    <= LOAD;
                in_ready_reg <= 1'b1;
              end
            end else begin
              word_cnt_reg <= word_cnt_reg + IDX_W'(1);
            end
          end
        end

        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg     <= IDLE;
          word_cnt_reg  <= '0;
          in_ready_reg  <= 1'b0;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_reg;
  assign load_en_o    = in_valid_i & in_ready_reg;
  assign out_valid_o  = out_valid_reg;
  assign word_idx_o   = word_cnt_reg;
  assign core_start_o = core_start_reg;
  assign busy_o       = busy_reg;
  assign done_o       = done_reg;
  assign blk_cnt_o    = blk_cnt_reg;

endmodule

// File: tb/tb_aes_engine_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_aes_engine_ctrl
// Randomized bench for aes_engine_ctrl. A job-level model tracks where the
// controller is inside the per-block timeline (load words, start, wait, unload
// words) and predicts every output each cycle; directed scenarios pin the model
// with hand-computed latencies and event counts.
// -----------------------------------------------------------------------------
module tb_aes_engine_ctrl;

  localparam int NW      = 4;
  localparam int CW      = 16;
  localparam int TIMEOUT = 16;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          start;
  logic [CW-1:0] nb_blocks;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    word_idx;
  logic          load_en;
  logic          core_start;
  logic          core_done;
  logic          busy;
  logic          done;
  logic [CW-1:0] blk_cnt;
  logic          err;

  aes_engine_ctrl #(
    .NB_WORDS      (NW),
    .BLK_CNT_W     (CW),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .start_i     (start),
    .nb_blocks_i (nb_blocks),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .word_idx_o  (word_idx),
    .load_en_o   (load_en),
    .core_start_o(core_start),
    .core_done_i (core_done),
    .busy_o      (busy),
    .done_o      (done),
    .blk_cnt_o   (blk_cnt),
    .err_o       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_pos walks the block timeline: 0..NW-1 load word m_pos, NW start,
  // NW+1 waiting for the core, NW+2..2*NW+1 unload word m_pos-NW-2.
  bit          m_active = 0;
  bit          m_done   = 0;
  bit          m_err    = 0;
  int          m_pos    = 0;
  int          m_wait   = 0;
  int          m_count  = 0;
  int          m_blk    = 0;

  always @(posedge clk) begin
    if (!rst_n || clear) begin
      m_active <= 0; m_done <= 0; m_err <= 0;
      m_pos <= 0; m_wait <= 0; m_count <= 0; m_blk <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (!m_active) begin
      if (start) begin
        m_count <= int'(nb_blocks);
        m_blk   <= 0;
        m_err   <= 0;
        m_pos   <= 0;
        if (nb_blocks != 0) m_active <= 1;
        else                m_done   <= 1;
      end
    end else if (m_pos < NW) begin
      if (in_valid) m_pos <= m_pos + 1;
    end else if (m_pos == NW) begin
      m_pos  <= NW + 1;
      m_wait <= 0;
    end else if (m_pos == NW + 1) begin
      if (core_done) begin
        m_pos <= NW + 2;
      end else begin
        m_wait <= m_wait + 1;
`ifdef AES_CTRL_TIMEOUT_EN
        if (m_wait + 1 == TIMEOUT) begin
          m_active <= 0; m_done <= 1; m_err <= 1; m_pos <= 0;
        end
`endif
      end
    end else if (out_ready) begin
      if (m_pos == 2 * NW + 1) begin
        m_blk <= m_blk + 1;
        m_pos <= 0;
        if (m_blk + 1 == m_count) begin
          m_active <= 0;
          m_done   <= 1;
        end
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  // ---------------- stimulus driver for the stream/core side ----------------
  int p_valid     = 100;
  int p_ready     = 100;
  int p_spur      = 0;
  int p_wait_done = 0;
  int done_delay  = 1;

  initial begin
    in_valid  = 0;
    out_ready = 0;
    core_done = 0;
    forever begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(99) < p_valid);
      out_ready = ($urandom_range(99) < p_ready);
      if (m_active && m_pos == NW + 1)
        core_done = (done_delay != 0 && m_wait == done_delay - 1) ||
                    ($urandom_range(99) < p_wait_done);
      else
        core_done = ($urandom_range(99) < p_spur);
    end
  end

  // ---------------- per-cycle compare + event counters ----------------
  int         n_cs = 0, n_done = 0, n_in_rdy = 0, n_out = 0, n_load = 0;
  logic [1:0] out_q[$];
  bit         prev_ov = 0, prev_or = 0, prev_rst = 1;
  logic [1:0] prev_idx = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        bit e_in_rdy, e_ov;
        int e_idx;
        e_in_rdy = m_active && (m_pos < NW);
        e_ov     = m_active && (m_pos >= NW + 2);
        e_idx    = (m_active && m_pos < NW) ? m_pos :
                   (m_active && m_pos >= NW + 2) ? m_pos - NW - 2 : 0;
        chk("in_ready",   in_ready,   e_in_rdy);
        chk("out_valid",  out_valid,  e_ov);
        chk("load_en",    load_en,    in_valid & e_in_rdy);
        chk("word_idx",   word_idx,   e_idx);
        chk("core_start", core_start, m_active && m_pos == NW);
        chk("busy",       busy,       m_active || m_done);
        chk("done",       done,       m_done);
        chk("blk_cnt",    blk_cnt,    m_blk);
`ifdef AES_CTRL_TIMEOUT_EN
        chk("err",        err,        m_err);
`else
        chk("err",        err,        0);
`endif
        if (prev_ov && !prev_or && !prev_rst) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_idx",   word_idx,  prev_idx);
        end
        n_cs     += int'(core_start);
        n_done   += int'(done);
        n_in_rdy += int'(in_ready);
        n_load   += int'(load_en);
        if (out_valid && out_ready) begin
          n_out++;
          out_q.push_back(word_idx);
        end
        prev_ov  = out_valid;
        prev_or  = out_ready;
        prev_idx = word_idx;
        prev_rst = !rst_n || clear;
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int nb);
    start     = 1;
    nb_blocks = CW'(nb);
    cyc();
    start     = 0;
    nb_blocks = CW'($urandom_range(65535));
  endtask

  // Counts negedges after the start edge until done_o; ends back in IDLE.
  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) chk("done_within_budget", 0, 1);
    cyc();
  endtask

  initial begin
    int lat, b_cs, b_done, b_rdy, b_out, b_load, b_q, guard;
    rst_n = 0; clear = 0; start = 0; nb_blocks = 0;
    cyc();
    chk_en = 1;
    cyc();
    @(negedge clk);
    chk("reset_busy",    busy,    0);
    chk("reset_blk_cnt", blk_cnt, 0);
    cyc();
    rst_n = 1;
    cyc();

    // 1: reset in the middle of LOAD after two beats
    p_valid = 100;
    b_load  = n_load;
    pulse_start(1);
    guard = 0;
    while (n_load - b_load < 2 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("t1_two_beats", n_load - b_load >= 2, 1);
    cyc();
    rst_n = 0;
    cyc();
    rst_n = 1;
    @(negedge clk);
    chk("t1_word_idx", word_idx, 0);
    chk("t1_busy",     busy,     0);
    chk("t1_in_ready", in_ready, 0);
    cyc();

    // 2: single block, core answers in its 10th wait cycle
    p_valid = 100; p_ready = 100; p_spur = 0; p_wait_done = 0; done_delay = 10;
    b_cs = n_cs; b_done = n_done; b_q = out_q.size();
    pulse_start(1);
    wait_done(100, lat);
    chk("t2_latency",   lat,           20);
    chk("t2_core_start", n_cs - b_cs,  1);
    chk("t2_done",      n_done - b_done, 1);
    chk("t2_blk_cnt",   blk_cnt,       1);
    chk("t2_out_beats", out_q.size() - b_q, 4);
    for (int i = 0; i < 4 && b_q + i < out_q.size(); i++)
      chk("t2_out_idx", out_q[b_q + i], i);

    // 3: three blocks with a 50% output stall rate
    p_ready = 50; done_delay = 3;
    b_out = n_out; b_done = n_done;
    pulse_start(3);
    wait_done(400, lat);
    chk("t3_out_beats", n_out - b_out,   12);
    chk("t3_blk_cnt",   blk_cnt,         3);
    chk("t3_done",      n_done - b_done, 1);

    // 4: empty job
    p_ready = 100;
    b_cs = n_cs; b_rdy = n_in_rdy; b_done = n_done;
    pulse_start(0);
    wait_done(10, lat);
    chk("t4_latency",    lat,             1);
    chk("t4_in_ready",   n_in_rdy - b_rdy, 0);
    chk("t4_core_start", n_cs - b_cs,     0);
    chk("t4_done",       n_done - b_done, 1);
    chk("t4_blk_cnt",    blk_cnt,         0);

    // 5: spurious core_done outside WAIT_CORE, start_i pulsed during WAIT_CORE
    p_spur = 40; done_delay = 6;
    b_cs = n_cs; b_done = n_done;
    pulse_start(2);
    guard = 0;
    while (!(m_active && m_pos == NW + 1) && guard < 50) begin
      cyc();
      guard++;
    end
    chk("t5_reached_wait", m_active && m_pos == NW + 1, 1);
    start = 1; nb_blocks = 7;
    cyc();
    start = 0;
    wait_done(200, lat);
    chk("t5_core_start", n_cs - b_cs,     2);
    chk("t5_blk_cnt",    blk_cnt,         2);
    chk("t5_done",       n_done - b_done, 1);
    p_spur = 0;

`ifdef AES_CTRL_TIMEOUT_EN
    // 6: core never answers -> watchdog ends the job
    done_delay = 0; p_wait_done = 0;
    pulse_start(1);
    wait_done(100, lat);
    chk("t6_latency", lat, 22);
    @(negedge clk);
    chk("t6_err_sticky", err, 1);
    cyc();
    done_delay = 1;
`endif

    // random phase: starts, block counts, clears and stream pressure all random
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        p_valid     = 30 + $urandom_range(70);
        p_ready     = 30 + $urandom_range(70);
        p_spur      = $urandom_range(40);
        p_wait_done = $urandom_range(30);
        done_delay  = 1 + $urandom_range(5);
      end
      start     = ($urandom_range(99) < 6);
      nb_blocks = CW'($urandom_range(3));
      clear     = ($urandom_range(399) == 0);
      cyc();
    end
    start = 0;
    clear = 0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
